xor_cipher_ctrl: RTL and testbench

Sequencing controller that time-shares one `deserializer` instance between key and plaintext loading, then produces the XOR ciphertext as a serial stream. It sits between the chip's serial input pins and the output pin: it gates the deserializer's enable and loading inputs, clears it between words, latches the key, and computes and shifts out `key ^ data` MSB first. One transaction is one key word, then one data word, then one output word.

---
 rtl/xor_cipher_ctrl.sv | 151 +++++++++++++++
 tb/tb_xor_cipher_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_cipher_ctrl.sv
// -----------------------------------------------------------------------------
// xor_cipher_ctrl
//
// Time-shares one external deserializer between loading a key word and a data
// word, then streams key ^ data out MSB first. One transaction is: clear
// deserializer, load key, latch key, clear deserializer, load data, compute
// ciphertext, shift it out.
//
// Parameters
//   DATA_SIZE     word width for key, data and ciphertext (>= 2)
//
// Ports
//   iClk          system clock, rising edge
//   iRst          asynchronous active-high reset
//   iStart        begin a transaction (only looked at in IDLE)
//   iBit_valid    serial input strobe, one bit accepted per high cycle
//   iDes_data     parallel word from the deserializer
//   oDes_rst_n    registered active-low clear for the deserializer
//   oDes_en       deserializer shift enable (strobe gated by LOAD states)
//   oDes_loading  registered, high only in LOAD_K / LOAD_D
//   oKey          latched key word
//   oSerial_out   ciphertext bit, MSB first
//   oOut_valid    high while oSerial_out carries a ciphertext bit
//   oBusy         high in every state except IDLE
//   oDone         one-cycle pulse after the last ciphertext bit
//   oState        current FSM encoding, for debug
// -----------------------------------------------------------------------------
module xor_cipher_ctrl #(
  parameter int DATA_SIZE = 32
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iStart,
  input  logic                 iBit_valid,
  input  logic [DATA_SIZE-1:0] iDes_data,
  output logic                 oDes_rst_n,
  output logic                 oDes_en,
  output logic                 oDes_loading,
  output logic [DATA_SIZE-1:0] oKey,
  output logic                 oSerial_out,
  output logic                 oOut_valid,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [2:0]           oState
);

  localparam int             CntW    = $clog2(DATA_SIZE) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLR_K   = 3'd1,
    LOAD_K  = 3'd2,
    LATCH_K = 3'd3,
    CLR_D   = 3'd4,
    LOAD_D  = 3'd5,
    XOR     = 3'd6,
    SHIFT   = 3'd7
  } state_t;

  state_t                 state;
  state_t                 nextState;
  logic [CntW-1:0]        bitCnt;
  logic [DATA_SIZE-1:0]   shiftReg;
  logic                   inLoad;
  logic                   cntLast;
  logic                   nextInClr;
  logic                   nextInLoad;

  assign inLoad     = (state == LOAD_K) || (state == LOAD_D);
  assign cntLast    = (bitCnt == LastCnt);
  assign nextInClr  = (nextState == CLR_K) || (nextState == CLR_D);
  assign nextInLoad = (nextState == LOAD_K) || (nextState == LOAD_D);

  // NOTE: every output of a combinational block gets a default first, so a
  // branch that forgets to assign it cannot infer a latch.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (iStart) nextState = CLR_K;
      CLR_K:   nextState = LOAD_K;
      LOAD_K:  if (iBit_valid && cntLast) nextState = LATCH_K;
      LATCH_K: nextState = CLR_D;
      CLR_D:   nextState = LOAD_D;
      LOAD_D:  if (iBit_valid && cntLast) nextState = XOR;
      XOR:     nextState = SHIFT;
      SHIFT:   if (cntLast) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // One counter serves both LOAD states (accepted bits) and SHIFT (cycles).
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      bitCnt <= '0;
    end else begin
      case (state)
        CLR_K, CLR_D, XOR: bitCnt <= '0;
        LOAD_K, LOAD_D:    if (iBit_valid) bitCnt <= bitCnt + 1'b1;
        SHIFT:             bitCnt <= bitCnt + 1'b1;
        default:           bitCnt <= bitCnt;
      endcase
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oKey     <= '0;
      shiftReg <= '0;
    end else begin
      if (state == LATCH_K) oKey <= iDes_data;
      if (state == XOR) begin
        shiftReg <= oKey ^ iDes_data;
      end else if (state == SHIFT) begin
        shiftReg <= {shiftReg[DATA_SIZE-2:0], 1'b0};
      end
    end
  end

  // Deserializer controls are decoded from the next state and registered so
  // the clear pulse is glitch-free and aligned exactly with CLR_K / CLR_D.
  // The clear is held low throughout reset so the deserializer clears too.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oDes_rst_n   <= 1'b0;
      oDes_loading <= 1'b0;
      oDone        <= 1'b0;
    end else begin
      oDes_rst_n   <= ~nextInClr;
      oDes_loading <= nextInLoad;
      oDone        <= (state == SHIFT) && cntLast;
    end
  end

  assign oDes_en     = iBit_valid & inLoad;
  assign oOut_valid  = (state == SHIFT);
  assign oSerial_out = (state == SHIFT) & shiftReg[DATA_SIZE-1];
  assign oBusy       = (state != IDLE);
  assign oState      = state;

endmodule

// File: tb/tb_xor_cipher_ctrl.sv
// -----------------------------------------------------------------------------
// tb_xor_cipher_ctrl
//
// Drives xor_cipher_ctrl (DATA_SIZE=8) together with a behavioural
// deserializer. Expected ciphertext is key ^ data; expected timing comes from
// the transaction length 3*N+5 with a continuous strobe.
// -----------------------------------------------------------------------------
module tb_xor_cipher_ctrl;

  localparam int N = 8;

  logic         iClk = 1'b0;
  logic         iRst;
  logic         iStart;
  logic         iBit_valid;
  logic [N-1:0] desReg;
  logic         desRstN;
  logic         desEn;
  logic         desLoading;
  logic [N-1:0] keyOut;
  logic         serOut;
  logic         outValid;
  logic         busy;
  logic         done;
  logic [2:0]   st;
  logic         serBit;

  int nChecks = 0;
  int nFails  = 0;

  xor_cipher_ctrl #(.DATA_SIZE(N)) dut (
    .iClk         (iClk),
    .iRst         (iRst),
    .iStart       (iStart),
    .iBit_valid   (iBit_valid),
    .iDes_data    (desReg),
    .oDes_rst_n   (desRstN),
    .oDes_en      (desEn),
    .oDes_loading (desLoading),
    .oKey         (keyOut),
    .oSerial_out  (serOut),
    .oOut_valid   (outValid),
    .oBusy        (busy),
    .oDone        (done),
    .oState       (st)
  );

  always #5 iClk = ~iClk;

  // Behavioural deserializer: MSB-first shift-in, async active-low clear.
  always_ff @(posedge iClk or negedge desRstN) begin
    if (!desRstN) begin
      desReg <= '0;
    end else if (desEn && desLoading) begin
      desReg <= {desReg[N-2:0], serBit};
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic pick_valid(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 0;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  // Runs one transaction from IDLE. Returns at the negedge where oDone is
  // seen, or right after asserting reset when abortCyc is reached.
  task automatic run_txn(
    input  logic [N-1:0] key,
    input  logic [N-1:0] data,
    input  int           mode,
    input  bit           busyStart,
    input  int           abortCyc,
    output logic [N-1:0] ctext,
    output int           lat,
    output int           accepted,
    output int           nClr,
    output bit           contig,
    output bit           aborted
  );
    logic [2*N-1:0] stream;
    int             idx;
    int             nValid;
    int             firstV;
    int             lastV;
    logic [2:0]     prevSt;
    bit             acc;
    stream  = {key, data};
    idx     = 0;
    ctext   = '0;
    lat     = -1;
    nClr    = 0;
    nValid  = 0;
    firstV  = -1;
    lastV   = -1;
    aborted = 1'b0;
    prevSt  = 3'd0;
    @(negedge iClk);
    iStart     = 1'b1;
    iBit_valid = pick_valid(mode, 0);
    serBit     = stream[2*N-1];
    #1 acc = desEn;
    check("en_in_idle", desEn, 1'b0);
    for (int cyc = 1; cyc <= 400 && lat < 0 && !aborted; cyc++) begin
      @(posedge iClk);
      if (acc) idx++;
      @(negedge iClk);
      iStart = 1'b0;
      if (cyc == abortCyc) begin
        check("abort_in_load_d", st, 3'd5);
        iRst = 1'b1;
        #1;
        check("rst_state", st, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_des_rst_n", desRstN, 1'b0);
        check("rst_key", keyOut, '0);
        check("rst_out_valid", outValid, 1'b0);
        aborted = 1'b1;
      end else begin
        if (!desRstN) begin
          nClr++;
          check("clr_only_in_clr_state", (st == 3'd1) || (st == 3'd4), 1'b1);
        end
        if (st == 3'd5 && prevSt == 3'd4) check("des_cleared_first_load_d", desReg, '0);
        if (outValid) begin
          ctext = {ctext[N-2:0], serOut};
          nValid++;
          if (firstV < 0) firstV = cyc;
          lastV = cyc;
        end
        if (done) begin
          lat = cyc;
          check("done_not_busy", busy, 1'b0);
          check("done_state_idle", st, 3'd0);
        end
        prevSt = st;
        if (busyStart && (cyc == 4 || cyc == 2*N+7)) iStart = 1'b1;
        iBit_valid = pick_valid(mode, cyc);
        serBit     = (idx < 2*N) ? stream[2*N-1-idx] : 1'b0;
        #1 acc = desEn;
        check("en_needs_valid", desEn & ~iBit_valid, 1'b0);
        check("en_only_in_load", desEn & ~((st == 3'd2) || (st == 3'd5)), 1'b0);
      end
    end
    accepted = idx;
    contig   = (nValid == N) && (lastV - firstV + 1 == N);
    if (lat < 0 && !aborted) check("txn_timeout", 1'b1, 1'b0);
  endtask

  typedef struct {
    logic [N-1:0] key;
    logic [N-1:0] data;
    int           mode;      // 0 continuous, 1 toggling, 2 random strobe
    bit           busyStart; // pulse iStart during LOAD_K and SHIFT
    logic [N-1:0] expOut;
    int           expLat;    // -1: not checked
  } vec_t;

  vec_t         vecs[7];
  logic [N-1:0] ctext;
  int           lat;
  int           accepted;
  int           nClr;
  bit           contig;
  bit           aborted;
  int           seen;

  initial begin
    vecs[0] = '{8'hA5, 8'h3C, 0, 1'b0, 8'h99, 3*N+5};
    vecs[1] = '{8'hA5, 8'h3C, 1, 1'b0, 8'h99, -1};
    vecs[2] = '{8'hFF, 8'hFF, 0, 1'b0, 8'h00, 3*N+5};
    vecs[3] = '{8'hA5, 8'h3C, 0, 1'b1, 8'h99, 3*N+5};
    vecs[4] = '{8'h00, 8'hFF, 0, 1'b0, 8'hFF, 3*N+5};
    vecs[5] = '{8'h80, 8'h01, 1, 1'b0, 8'h81, -1};
    vecs[6] = '{8'h5A, 8'h5A, 2, 1'b0, 8'h00, -1};

    iRst       = 1'b1;
    iStart     = 1'b0;
    iBit_valid = 1'b0;
    serBit     = 1'b0;
    #3;
    check("reset_state", st, 3'd0);
    check("reset_des_rst_n", desRstN, 1'b0);
    check("reset_key", keyOut, '0);
    check("reset_serial_out", serOut, 1'b0);
    check("reset_out_valid", outValid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_des_loading", desLoading, 1'b0);
    @(negedge iClk);
    iRst = 1'b0;
    @(posedge iClk);
    #1 check("des_rst_n_after_reset", desRstN, 1'b1);

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].key, vecs[i].data, vecs[i].mode, vecs[i].busyStart, -1,
              ctext, lat, accepted, nClr, contig, aborted);
      check($sformatf("vec%0d_ctext", i), ctext, vecs[i].expOut);
      check($sformatf("vec%0d_key", i), keyOut, vecs[i].key);
      check($sformatf("vec%0d_accepted", i), accepted, 2*N);
      check($sformatf("vec%0d_clears", i), nClr, 2);
      check($sformatf("vec%0d_contiguous", i), contig, 1'b1);
      if (vecs[i].expLat >= 0) check($sformatf("vec%0d_latency", i), lat, vecs[i].expLat);
    end

    // Random words and random strobe against key ^ data.
    for (int i = 0; i < 20; i++) begin
      logic [N-1:0] k;
      logic [N-1:0] d;
      k = N'($urandom);
      d = N'($urandom);
      run_txn(k, d, 2, 1'b0, -1, ctext, lat, accepted, nClr, contig, aborted);
      check("rand_ctext", ctext, k ^ d);
      check("rand_key", keyOut, k);
      check("rand_accepted", accepted, 2*N);
    end

    // Start in the oDone cycle launches a new transaction immediately.
    run_txn(8'h12, 8'h34, 0, 1'b0, -1, ctext, lat, accepted, nClr, contig, aborted);
    check("chain_ctext", ctext, 8'h26);
    iStart = 1'b1;
    @(posedge iClk);
    #1;
    check("chain_start_clr_k", st, 3'd1);
    check("chain_start_busy", busy, 1'b1);
    iStart = 1'b0;
    @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    @(posedge iClk);

    // Reset in the middle of LOAD_D discards everything.
    run_txn(8'hA5, 8'h3C, 0, 1'b0, 15, ctext, lat, accepted, nClr, contig, aborted);
    check("abort_taken", aborted, 1'b1);
    @(negedge iClk);
    iRst       = 1'b0;
    iBit_valid = 1'b1;
    @(posedge iClk);
    #1 check("des_rst_n_release", desRstN, 1'b1);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge iClk);
      if (outValid) seen++;
    end
    check("no_output_after_reset", seen, 0);
    check("idle_after_reset", st, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
